// File: rtl/rv32f_types_pkg.sv
// Shared types for the RV32F issue controller: FSM state encoding and default abort limit.
package rv32f_types_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WB   = 2'd2
  } fpu_ctrl_state_t;

  localparam int FPU_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/fpu_scoreboard.sv
// 32-entry busy scoreboard for FP registers: one set, one clear, clear-all, three read ports.
module fpu_scoreboard (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_en,
  input  logic [4:0] set_idx,
  input  logic       clr_en,
  input  logic [4:0] clr_idx,
  input  logic       clr_all,
  input  logic [4:0] rd_idx_a,
  input  logic [4:0] rd_idx_b,
  input  logic [4:0] rd_idx_c,
  output logic       rd_a,
  output logic       rd_b,
  output logic       rd_c
);

  logic [31:0] busy;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask = 32'd1 << set_idx;
    if (clr_en) clr_mask = 32'd1 << clr_idx;
  end

  // NOTE: the busy vector is control state, not storage, so it must be reset; a stale bit would stall forever.
  // The set mask is OR-ed in last so a same-cycle set beats any clear.
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= (busy & ~clr_mask & {32{~clr_all}}) | set_mask;
  end

  assign rd_a = busy[rd_idx_a];
  assign rd_b = busy[rd_idx_b];
  assign rd_c = busy[rd_idx_c];

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Single-op FP issue controller: hazard check, issue, timeout abort, and FP register-file write arbitration.
module fpu_issue_ctrl
  import rv32f_types_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = FPU_TIMEOUT_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dec_valid,
  input  logic [6:0]  fpu_op,
  input  logic        dec_flw,
  input  logic [4:0]  f_rs1,
  input  logic [4:0]  f_rs2,
  input  logic [4:0]  f_rd,
  input  logic [2:0]  f_frm,
  input  logic        flush,
  input  logic        flw_valid,
  input  logic [4:0]  flw_rd,
  input  logic [31:0] flw_data,
  output logic        fpu_start,
  output logic        fpu_abort,
  output logic [6:0]  fpu_op_o,
  output logic [2:0]  fpu_frm_o,
  output logic [4:0]  fpu_rs1_o,
  output logic [4:0]  fpu_rs2_o,
  input  logic        fpu_done,
  input  logic [31:0] fpu_result,
  input  logic [4:0]  fpu_flags,
  output logic        frf_wen,
  output logic [4:0]  frf_waddr,
  output logic [31:0] frf_wdata,
  output logic        fflags_wen,
  output logic [4:0]  fflags,
  output logic        stall,
  output logic        fpu_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  fpu_ctrl_state_t  state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       rd_q;
  logic [31:0]      result_q;
  logic [4:0]       flags_q;

  logic fp_req, hz_rs1, hz_rs2, hz_rd, hazard, issue;
  logic wb_retire, timeout_hit, sb_clr_en, sb_clr_all;

  fpu_scoreboard u_scoreboard (
    .clk      (CLK),
    .rst      (RST),
    .set_en   (issue),
    .set_idx  (f_rd),
    .clr_en   (sb_clr_en),
    .clr_idx  (rd_q),
    .clr_all  (sb_clr_all),
    .rd_idx_a (f_rs1),
    .rd_idx_b (f_rs2),
    .rd_idx_c (f_rd),
    .rd_a     (hz_rs1),
    .rd_b     (hz_rs2),
    .rd_c     (hz_rd)
  );

  // An FLW return always owns the write port; the held FPU result retires only on a free cycle.
  always_comb begin
    fp_req      = dec_valid & (fpu_op != '0);
    hazard      = hz_rs1 | hz_rs2 | hz_rd;
    issue       = (state == IDLE) & fp_req & ~hazard & ~flush;
    timeout_hit = (state == BUSY) & ~flush & ~fpu_done & (cnt == CNT_LAST);
    wb_retire   = (state == WB) & ~flw_valid & ~flush & ~RST;
    sb_clr_en   = wb_retire | timeout_hit;
    sb_clr_all  = flush & (state != IDLE);
    stall       = (fp_req & ((state != IDLE) | hazard)) | (dec_valid & dec_flw & hz_rd);
    frf_wen     = flw_valid | wb_retire;
    frf_waddr   = flw_valid ? flw_rd : rd_q;
    frf_wdata   = flw_valid ? flw_data : result_q;
    fflags_wen  = wb_retire;
    fflags      = flags_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= '0;
      rd_q        <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      fpu_start   <= 1'b0;
      fpu_abort   <= 1'b0;
      fpu_timeout <= 1'b0;
      fpu_op_o    <= '0;
      fpu_frm_o   <= '0;
      fpu_rs1_o   <= '0;
      fpu_rs2_o   <= '0;
    end else begin
      fpu_start   <= 1'b0;
      fpu_abort   <= 1'b0;
      fpu_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            fpu_start <= 1'b1;
            fpu_op_o  <= fpu_op;
            fpu_frm_o <= f_frm;
            fpu_rs1_o <= f_rs1;
            fpu_rs2_o <= f_rs2;
            rd_q      <= f_rd;
            cnt       <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (flush) begin
            fpu_abort <= 1'b1;
            state     <= IDLE;
          end else if (fpu_done) begin
            result_q <= fpu_result;
            flags_q  <= fpu_flags;
            state    <= WB;
          end else if (cnt == CNT_LAST) begin
            fpu_timeout <= 1'b1;
            fpu_abort   <= 1'b1;
            state       <= IDLE;
          end
        end
        WB: begin
          if (flush) begin
            fpu_abort <= 1'b1;
            state     <= IDLE;
          end else if (!flw_valid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
